imm_encoder: RTL and testbench

// - Packs a 32-bit signed/unsigned immediate into the scattered immediate fields of a RISC-V
//   (RV32I) instruction word. Formats: I, S, B, U, J. Inverse of the decode-side immediate

---
 rtl/imm_encoder.sv | 136 +++++++++++++
 tb/tb_imm_encoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Packs an immediate into the scattered I/S/B/U/J fields of an RV32I instruction word.
// Two-stage valid/ready pipeline (range check, then packing) with saturating good/bad counters.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);

    localparam logic [2:0] OP_I = 3'b000;
    localparam logic [2:0] OP_S = 3'b001;
    localparam logic [2:0] OP_B = 3'b010;
    localparam logic [2:0] OP_U = 3'b011;
    localparam logic [2:0] OP_J = 3'b100;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic        s1_valid;
    logic [2:0]  s1_op;
    logic [31:0] s1_imm;
    logic [31:0] s1_inst;
    logic        s1_err;
    logic        s2_valid;
    logic        s1_adv;
    logic        s2_adv;
    logic        err_chk;
    logic [31:0] packed_word;

    // Handshake: a transfer happens on a rising edge where valid && ready; valid
    // holds with its data until taken, ready is combinational and may depend on
    // the downstream ready (no skid buffer).
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Sign-extension checks: the dropped upper bits must all equal the kept sign bit.
    always_comb begin
        err_chk = 1'b1;
        case (in_op)
            OP_I, OP_S: err_chk = !((&in_imm[31:11]) || (~|in_imm[31:11]));
            OP_B:       err_chk = !((&in_imm[31:12]) || (~|in_imm[31:12])) || in_imm[0];
            OP_U:       err_chk = |in_imm[11:0];
            OP_J:       err_chk = !((&in_imm[31:20]) || (~|in_imm[31:20])) || in_imm[0];
            default:    err_chk = 1'b1;
        endcase
    end

    always_comb begin
        packed_word = s1_inst;
        case (s1_op)
            OP_I: packed_word[31:20] = s1_imm[11:0];
            OP_S: begin
                packed_word[31:25] = s1_imm[11:5];
                packed_word[11:7]  = s1_imm[4:0];
            end
            OP_B: begin
                packed_word[31]    = s1_imm[12];
                packed_word[30:25] = s1_imm[10:5];
                packed_word[11:8]  = s1_imm[4:1];
                packed_word[7]     = s1_imm[11];
            end
            OP_U: packed_word[31:12] = s1_imm[31:12];
            OP_J: begin
                packed_word[31]    = s1_imm[20];
                packed_word[30:21] = s1_imm[10:1];
                packed_word[20]    = s1_imm[11];
                packed_word[19:12] = s1_imm[19:12];
            end
            default: packed_word = s1_inst;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= 3'b000;
            s1_imm   <= 32'h0;
            s1_inst  <= 32'h0;
            s1_err   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op   <= in_op;
                s1_imm  <= in_imm;
                s1_inst <= in_inst;
                s1_err  <= err_chk;
            end
        end
    end

    // Output registers only load on a real transfer, so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_inst <= 32'h0;
            out_err  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_inst <= packed_word;
                out_err  <= s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ok  <= '0;
            cnt_err <= '0;
        end else if (cnt_clr) begin
            cnt_ok  <= '0;
            cnt_err <= '0;
        end else if (s2_valid && out_ready) begin
            if (out_err) begin
                if (cnt_err != CNT_MAX) cnt_err <= cnt_err + CNT_ONE;
            end else begin
                if (cnt_ok != CNT_MAX) cnt_ok <= cnt_ok + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors, backpressure, random traffic vs. a
// bit-mapping reference model, mid-flight reset and counter saturation/clear.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_imm;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic        cnt_clr;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_ok = 0;
    int exp_err = 0;
    logic [32:0] exp_q[$];

    imm_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_imm(in_imm), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err),
        .cnt_clr(cnt_clr), .cnt_ok(cnt_ok), .cnt_err(cnt_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        in_valid = 1'b0; in_op = 3'b0; in_imm = 32'h0; in_inst = 32'h0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_ok = 0; exp_err = 0;
    endtask

    // ---------------- reference model ----------------
    // Range from signed arithmetic, packing from explicit per-bit destination lists.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] imm,
                                          input logic [31:0] inst);
        int sv;
        logic err;
        logic [31:0] w;
        sv = $signed(imm);
        w = inst;
        err = 1'b1;
        case (op)
            3'd0: begin
                err = (sv < -2048) || (sv > 2047);
                for (int k = 0; k < 12; k++) w[20+k] = imm[k];
            end
            3'd1: begin
                err = (sv < -2048) || (sv > 2047);
                for (int k = 0; k < 5; k++) w[7+k] = imm[k];
                for (int k = 5; k < 12; k++) w[20+k] = imm[k];
            end
            3'd2: begin
                err = (sv < -4096) || (sv > 4095) || (imm % 2 != 0);
                w[31] = imm[12];
                for (int k = 5; k < 11; k++) w[20+k] = imm[k];
                for (int k = 1; k < 5; k++) w[7+k] = imm[k];
                w[7] = imm[11];
            end
            3'd3: begin
                err = (imm % 4096) != 0;
                for (int k = 12; k < 32; k++) w[k] = imm[k];
            end
            3'd4: begin
                err = (sv < -(1 << 20)) || (sv >= (1 << 20)) || (imm % 2 != 0);
                w[31] = imm[20];
                for (int k = 1; k < 11; k++) w[20+k] = imm[k];
                w[20] = imm[11];
                for (int k = 12; k < 20; k++) w[k] = imm[k];
            end
            default: err = 1'b1;
        endcase
        return {err, w};
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle at the falling edge and samples outputs just after; the
    // handshake itself happens on the following rising edge.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] imm,
                        input logic [31:0] inst, input logic ordy, input logic clr,
                        output logic acc, output logic ov, output logic [31:0] oi,
                        output logic oe);
        @(negedge clk);
        in_valid = v; in_op = op; in_imm = imm; in_inst = inst;
        out_ready = ordy; cnt_clr = clr;
        #1;
        acc = v && in_ready;
        ov  = out_valid;
        oi  = out_inst;
        oe  = out_err;
        if (clr) begin
            exp_ok = 0; exp_err = 0;
        end else if (ov && ordy) begin
            if (oe) exp_err++; else exp_ok++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic acc, ov, oe;
        logic [31:0] oi;
        do_reset();
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, acc, ov, oi, oe);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        total_cnt++; if (ov !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", ov); else pass_cnt++;
        total_cnt++; if ({oe, oi} !== 33'h0) $display("FAIL reset_out got=%b/%h exp=0/0", oe, oi); else pass_cnt++;
        total_cnt++; if (cnt_ok !== 16'h0 || cnt_err !== 16'h0)
            $display("FAIL reset_counters got=%h/%h exp=0/0", cnt_ok, cnt_err); else pass_cnt++;
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] imm;
        logic [31:0] inst;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[0:10];
        logic acc, ov, oe;
        logic [31:0] oi;
        vecs = '{
            {3'd0, 32'hFFFFFFFF, 32'h00000093, 32'hFFF00093, 1'b0},
            {3'd0, 32'h000007FF, 32'h00000013, 32'h7FF00013, 1'b0},
            {3'd1, 32'hFFFFF800, 32'h00112023, 32'h80112023, 1'b0},
            {3'd1, 32'h00000800, 32'h00112023, 32'h80112023, 1'b1},
            {3'd2, 32'h00000010, 32'h00208063, 32'h00208863, 1'b0},
            {3'd2, 32'h00000011, 32'h00208063, 32'h00208863, 1'b1},
            {3'd4, 32'hFFFFFFFC, 32'h0000006F, 32'hFFDFF06F, 1'b0},
            {3'd4, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1},
            {3'd3, 32'h12345000, 32'h000000B7, 32'h123450B7, 1'b0},
            {3'd3, 32'h12345001, 32'h000000B7, 32'h123450B7, 1'b1},
            {3'd7, 32'h00000000, 32'h12345678, 32'h12345678, 1'b1}
        };
        for (int i = 0; i < 11; i++) begin
            step(1'b1, vecs[i].op, vecs[i].imm, vecs[i].inst, 1'b1, 1'b0, acc, ov, oi, oe);
            total_cnt++; if (acc !== 1'b1) $display("FAIL dir_accept[%0d] got=%b exp=1", i, acc); else pass_cnt++;
            step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
            total_cnt++; if (ov !== 1'b0) $display("FAIL dir_early_valid[%0d] got=%b exp=0", i, ov); else pass_cnt++;
            step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
            total_cnt++; if (ov !== 1'b1) $display("FAIL dir_latency[%0d] got=%b exp=1", i, ov); else pass_cnt++;
            total_cnt++;
            if (oi !== vecs[i].exp_inst || oe !== vecs[i].exp_err)
                $display("FAIL dir_word[%0d] got=%h/%b exp=%h/%b", i, oi, oe, vecs[i].exp_inst, vecs[i].exp_err);
            else pass_cnt++;
            step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
            total_cnt++;
            if (cnt_ok !== 16'(exp_ok) || cnt_err !== 16'(exp_err))
                $display("FAIL dir_counters[%0d] got=%0d/%0d exp=%0d/%0d", i, cnt_ok, cnt_err, exp_ok, exp_err);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic acc, ov, oe;
        logic [31:0] oi;
        logic [31:0] imm;
        int got;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            imm = 32'h100 + 32'(i);
            step(1'b1, 3'd0, imm, 32'h00000013, 1'b0, 1'b0, acc, ov, oi, oe);
            if (i < 2) begin
                total_cnt++; if (acc !== 1'b1) $display("FAIL bp_accept[%0d] got=%b exp=1", i, acc); else pass_cnt++;
            end else begin
                total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got=%b exp=0", in_ready); else pass_cnt++;
            end
            if (acc) exp_q.push_back(model(3'd0, imm, 32'h00000013));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, acc, ov, oi, oe);
            total_cnt++;
            if (ov !== 1'b1 || {oe, oi} !== exp_q[0])
                $display("FAIL bp_stall_stable[%0d] got=%b/%b/%h exp=1/%b/%h", i, ov, oe, oi, exp_q[0][32], exp_q[0][31:0]);
            else pass_cnt++;
        end
        got = 0;
        for (int t = 0; t < 10; t++) begin
            step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
            if (ov) begin
                got++;
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL bp_extra got=%h exp=none", oi);
                else if ({oe, oi} !== exp_q[0]) $display("FAIL bp_order got=%b/%h exp=%b/%h", oe, oi, exp_q[0][32], exp_q[0][31:0]);
                else pass_cnt++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        total_cnt++; if (got !== 2) $display("FAIL bp_count got=%0d exp=2", got); else pass_cnt++;
    endtask

    task automatic test_random();
        logic acc, ov, oe, v, ordy;
        logic [31:0] oi, imm, inst, prev_oi;
        logic [2:0] op;
        logic prev_stall, prev_oe;
        int drain;
        exp_q.delete();
        prev_stall = 1'b0; prev_oi = 32'h0; prev_oe = 1'b0;
        for (int c = 0; c < 800; c++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            op   = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            inst = $urandom;
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($signed($urandom_range(0, 10000)) - 5000);
                2: imm = $urandom & 32'hFFFFF000;
                default: imm = 32'($signed($urandom_range(0, 4200000)) - 2100000);
            endcase
            step(v, op, imm, inst, ordy, 1'b0, acc, ov, oi, oe);
            if (prev_stall) begin
                total_cnt++;
                if (ov !== 1'b1 || oi !== prev_oi || oe !== prev_oe)
                    $display("FAIL rnd_stall_hold got=%b/%b/%h exp=1/%b/%h", ov, oe, oi, prev_oe, prev_oi);
                else pass_cnt++;
            end
            if (acc) exp_q.push_back(model(op, imm, inst));
            if (ov && ordy) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL rnd_extra got=%b/%h exp=none", oe, oi);
                else if ({oe, oi} !== exp_q[0]) $display("FAIL rnd_word got=%b/%h exp=%b/%h", oe, oi, exp_q[0][32], exp_q[0][31:0]);
                else pass_cnt++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            prev_stall = ov && !ordy;
            prev_oi = oi; prev_oe = oe;
        end
        drain = 0;
        while (exp_q.size() != 0 && drain < 50) begin
            step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
            if (ov) begin
                total_cnt++;
                if ({oe, oi} !== exp_q[0]) $display("FAIL rnd_drain got=%b/%h exp=%b/%h", oe, oi, exp_q[0][32], exp_q[0][31:0]);
                else pass_cnt++;
                void'(exp_q.pop_front());
            end
            drain++;
        end
        total_cnt++; if (exp_q.size() != 0) $display("FAIL rnd_drain_timeout got=%0d left exp=0", exp_q.size()); else pass_cnt++;
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
        total_cnt++;
        if (cnt_ok !== 16'(exp_ok) || cnt_err !== 16'(exp_err))
            $display("FAIL rnd_counters got=%0d/%0d exp=%0d/%0d", cnt_ok, cnt_err, exp_ok, exp_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        logic acc, ov, oe;
        logic [31:0] oi;
        step(1'b1, 3'd0, 32'h5, 32'h13, 1'b0, 1'b0, acc, ov, oi, oe);
        step(1'b1, 3'd0, 32'h6, 32'h13, 1'b0, 1'b0, acc, ov, oi, oe);
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, acc, ov, oi, oe);
        total_cnt++; if (ov !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL rst_pre_full got=%b/%b exp=1/0", ov, in_ready); else pass_cnt++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_async_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (cnt_ok !== 16'h0 || cnt_err !== 16'h0)
            $display("FAIL rst_async_counters got=%h/%h exp=0/0", cnt_ok, cnt_err); else pass_cnt++;
        in_valid = 1'b0;
        exp_q.delete(); exp_ok = 0; exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'd0, 32'hFFFFFFFF, 32'h00000093, 1'b1, 1'b0, acc, ov, oi, oe);
        total_cnt++; if (acc !== 1'b1) $display("FAIL rst_post_accept got=%b exp=1", acc); else pass_cnt++;
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
        total_cnt++; if (ov !== 1'b1 || oi !== 32'hFFF00093 || oe !== 1'b0)
            $display("FAIL rst_post_word got=%b/%h/%b exp=1/fff00093/0", ov, oi, oe); else pass_cnt++;
    endtask

    task automatic test_counters();
        logic acc, ov, oe;
        logic [31:0] oi;
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1, acc, ov, oi, oe);
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
        total_cnt++; if (cnt_ok !== 16'h0) $display("FAIL cnt_clear got=%h exp=0", cnt_ok); else pass_cnt++;
        for (int i = 0; i < 65540; i++)
            step(1'b1, 3'd0, 32'h0, 32'h13, 1'b1, 1'b0, acc, ov, oi, oe);
        repeat (3) step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
        total_cnt++; if (cnt_ok !== 16'hFFFF) $display("FAIL cnt_saturate got=%h exp=ffff", cnt_ok); else pass_cnt++;
        total_cnt++; if (cnt_err !== 16'h0) $display("FAIL cnt_err_idle got=%h exp=0", cnt_err); else pass_cnt++;
        step(1'b1, 3'd0, 32'h1, 32'h13, 1'b1, 1'b0, acc, ov, oi, oe);
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1, acc, ov, oi, oe);
        total_cnt++; if (ov !== 1'b1) $display("FAIL cnt_clr_handshake_valid got=%b exp=1", ov); else pass_cnt++;
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
        total_cnt++; if (cnt_ok !== 16'h0) $display("FAIL cnt_clr_priority got=%h exp=0", cnt_ok); else pass_cnt++;
        step(1'b1, 3'd7, 32'h0, 32'h13, 1'b1, 1'b0, acc, ov, oi, oe);
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, acc, ov, oi, oe);
        total_cnt++; if (cnt_err !== 16'h1 || cnt_ok !== 16'h0)
            $display("FAIL cnt_after_clear got=%h/%h exp=0/1", cnt_ok, cnt_err); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_counters();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
